// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared state encoding and constants for the instruction-fetch controller
package if_pkg;

  typedef enum logic [2:0] {
    IF_IDLE,
    IF_LOAD,
    IF_WAIT,
    IF_HOLD,
    IF_DRAIN
  } if_state_e;

  localparam logic [31:0] INST_NOP = 32'h0;

endpackage

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - PC-driven instruction fetch with one-entry skid buffer and flush drain
module if_fetch_ctrl
  import if_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  input  logic        id_stall_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        stall_o,
  output logic        pc_enable_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o
);

  if_state_e   state_q;
  logic [31:0] skid_data_q;
  logic [31:0] skid_addr_q;
  logic        out_free;

  assign out_free  = ~inst_valid_o | ~id_stall_i;
  assign mem_req_o = (state_q == IF_WAIT) || (state_q == IF_DRAIN);
  assign stall_o   = start_i & ~pc_enable_o;

  // The PC advances exactly when an instruction lands in IF/ID or a redirect is taken.
  always_comb begin
    pc_enable_o = 1'b0;
    if (flush_i && state_q != IF_IDLE) begin
      pc_enable_o = 1'b1;
    end else begin
      case (state_q)
        IF_WAIT: pc_enable_o = mem_ack_i & out_free;
        IF_HOLD: pc_enable_o = ~id_stall_i;
        default: pc_enable_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IF_IDLE;
      mem_addr_o   <= '0;
      inst_o       <= INST_NOP;
      inst_pc_o    <= '0;
      inst_valid_o <= 1'b0;
      skid_data_q  <= INST_NOP;
      skid_addr_q  <= '0;
    end else if (flush_i && state_q != IF_IDLE) begin
      // An outstanding request cannot be withdrawn, so it is drained with its address held.
      inst_valid_o <= 1'b0;
      skid_data_q  <= INST_NOP;
      skid_addr_q  <= '0;
      state_q      <= (mem_req_o && !mem_ack_i) ? IF_DRAIN : IF_LOAD;
    end else begin
      if (inst_valid_o && !id_stall_i) begin
        inst_valid_o <= 1'b0;
      end
      case (state_q)
        IF_IDLE: begin
          if (start_i) begin
            state_q <= IF_LOAD;
          end
        end
        IF_LOAD: begin
          mem_addr_o <= pc_i;
          state_q    <= IF_WAIT;
        end
        IF_WAIT: begin
          if (mem_ack_i) begin
            if (out_free) begin
              inst_o       <= mem_data_i;
              inst_pc_o    <= mem_addr_o;
              inst_valid_o <= 1'b1;
              state_q      <= IF_LOAD;
            end else begin
              skid_data_q <= mem_data_i;
              skid_addr_q <= mem_addr_o;
              state_q     <= IF_HOLD;
            end
          end
        end
        IF_HOLD: begin
          if (!id_stall_i) begin
            inst_o       <= skid_data_q;
            inst_pc_o    <= skid_addr_q;
            inst_valid_o <= 1'b1;
            state_q      <= IF_LOAD;
          end
        end
        IF_DRAIN: begin
          if (mem_ack_i) begin
            state_q <= IF_LOAD;
          end
        end
        default: state_q <= IF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - randomized scoreboard bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] pc_i;
  logic        flush_i = 1'b0;
  logic        id_stall_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_data_i = 32'h0;
  logic        stall_o;
  logic        pc_enable_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  if_fetch_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .id_stall_i   (id_stall_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i),
    .stall_o      (stall_o),
    .pc_enable_o  (pc_enable_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_valid_o (inst_valid_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[17:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // PC register model: +4 on enable, redirect target when flushing.
  logic [31:0] pc_q;
  logic [31:0] flush_tgt = 32'h0;
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) pc_q <= 32'h0;
    else if (pc_enable_o) pc_q <= flush_i ? flush_tgt : pc_q + 32'd4;
  end
  assign pc_i = pc_q;

  int wcnt = 0;
  int kcur = 1;
  int kfix = 1;
  bit rand_mode = 0;
  bit run = 0;
  bit dir = 0;

  // One cycle of stimulus: memory responder plus randomized control inputs.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (mem_req_o) begin
      wcnt++;
      mem_ack_i = (wcnt == kcur);
    end else begin
      wcnt = 0;
      mem_ack_i = 1'b0;
      kcur = (kfix != 0) ? kfix : int'($urandom_range(1, 3));
    end
    mem_data_i = mem_ack_i ? mem_word(mem_addr_o) : 32'hDEAD_BEEF;
    if (rand_mode) begin
      id_stall_i = ($urandom_range(0, 3) == 0);
      flush_i    = run && ($urandom_range(0, 15) == 0);
      flush_tgt  = 32'($urandom_range(16, 255)) << 2;
    end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } item_t;

  item_t       sb[$];
  bit          taint = 0;
  bit          skid_pend = 0;
  bit          have_last = 0;
  bit          first_pending = 1;
  bit          req_d = 0;
  logic [31:0] addr_d = 32'h0;
  logic [31:0] exp_next = 32'h0;
  int          cyc = 0;
  int          start_cyc = -1;
  int          last_cyc = 0;
  int          last_k = 0;
  int          idle_run = 0;
  int          consumed = 0;

  // Monitor: decides what the DUT should be doing this cycle from the fetch-level model.
  always @(negedge clk_i) begin
    bit    ack_ok;
    bit    out_free;
    bit    exp_en;
    item_t it;
    cyc++;
    if (!rst_i) begin
      sb.delete();
      taint = 0;
      skid_pend = 0;
      have_last = 0;
      req_d = 0;
      exp_next = 32'h0;
    end else begin
      if (start_i && start_cyc < 0) start_cyc = cyc;
      ack_ok   = mem_req_o && mem_ack_i && !flush_i && !taint;
      out_free = !inst_valid_o || !id_stall_i;
      exp_en   = flush_i || (ack_ok && out_free) || (skid_pend && !id_stall_i);
      chk("pc_enable", 32'(pc_enable_o), 32'(exp_en));
      chk("stall", 32'(stall_o), 32'(start_i && !exp_en));
      chk("valid_vs_model", 32'(inst_valid_o), 32'(sb.size() != 0));
      if (mem_req_o && !req_d) chk("req_addr", mem_addr_o, pc_i);
      if (mem_req_o && req_d) chk("addr_stable", mem_addr_o, addr_d);
      if (inst_valid_o && first_pending) begin
        chk("first_latency", 32'(cyc - start_cyc), 32'(kfix + 2));
        first_pending = 0;
      end
      if (inst_valid_o && !id_stall_i && !flush_i && sb.size() != 0) begin
        it = sb.pop_front();
        consumed++;
        chk("inst_pc", inst_pc_o, it.a);
        chk("inst", inst_o, it.d);
        chk("pc_seq", it.a, exp_next);
        exp_next = it.a + 32'd4;
        if (dir && have_last && last_k == kfix) chk("interval", 32'(cyc - last_cyc), 32'(kfix + 1));
        have_last = 1;
        last_cyc = cyc;
        last_k = kfix;
      end
      if (skid_pend && !id_stall_i) skid_pend = 0;
      if (mem_req_o && mem_ack_i) begin
        if (ack_ok) begin
          it.a = mem_addr_o;
          it.d = mem_word(mem_addr_o);
          sb.push_back(it);
          if (!out_free) skid_pend = 1;
        end
        taint = 0;
      end else if (mem_req_o && flush_i) begin
        taint = 1;
      end
      if (flush_i) begin
        sb.delete();
        skid_pend = 0;
        have_last = 0;
        exp_next = flush_tgt;
      end
      if (run && !pc_enable_o) idle_run++;
      else idle_run = 0;
      if (idle_run > 40) begin
        chk("watchdog_progress", 32'(idle_run), 32'd0);
        idle_run = 0;
      end
      req_d = mem_req_o;
      addr_d = mem_addr_o;
    end
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_inst_pc", inst_pc_o, 32'h0);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_pc_enable", 32'(pc_enable_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);

    // Directed: single-wait memory, then 3-wait memory, no stalls or flushes.
    dir = 1;
    kfix = 1;
    step();
    start_i = 1'b1;
    repeat (12) step();
    kfix = 3;
    repeat (30) step();
    dir = 0;

    kfix = 0;
    rand_mode = 1;
    run = 1;
    repeat (3000) step();

    // Reset in the middle of a memory request.
    rand_mode = 0;
    run = 0;
    flush_i = 1'b0;
    id_stall_i = 1'b0;
    kfix = 2;
    for (int i = 0; i < 30 && !mem_req_o; i++) step();
    chk("reached_wait", 32'(mem_req_o), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("async_rst_req", 32'(mem_req_o), 32'd0);
    chk("async_rst_valid", 32'(inst_valid_o), 32'd0);
    repeat (2) step();
    rst_i = 1'b1;
    repeat (10) step();

    kfix = 0;
    rand_mode = 1;
    run = 1;
    repeat (1000) step();
    rand_mode = 0;
    run = 0;
    flush_i = 1'b0;
    id_stall_i = 1'b0;
    repeat (20) step();
    chk("consumed_any", 32'(consumed > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
